predictor_flow_control_loop_pipe_credit: RTL and testbench
==========================================================

Name: predictor_flow_control_loop_pipe_credit

Overview:
- Parametrised successor of the sequential-init loop flow-control wrapper used around HLS pipelined loop bodies in the predictor.
- Adds a real ap_continue handshake with a DONE_DEPTH-deep done-token credit counter, back-pressure to the loop body, and an ap_loop_init window spanning INIT_ITERS iterations.
- Adds idle/busy tracking and a sticky overflow error.
- Sits between the parent FSM (ap_start/ap_done/ap_continue) and the loop-body pipeline (the *_int signals).

Parameters:
- DONE_DEPTH, 2: max completed runs held awaiting consumption (1..15).
- CNT_W, 4: width of the done-token counter; must satisfy 2^CNT_W > DONE_DEPTH.
- HAS_CONTINUE, 1: 1 = tokens consumed by ap_done&ap_continue; 0 = tokens consumed by ap_done&ap_start (legacy start-handshake mode).
- INIT_ITERS, 1: number of ap_ready_int pulses for which ap_loop_init stays armed (1..255).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  parent start request.
- ap_continue  in  1  parent accepts a done token (ignored when HAS_CONTINUE=0).
- ap_ready  out  1  equals ap_loop_exit_ready.
- ap_done  out  1  a completed run is available to the parent.
- ap_idle  out  1  no run active and no tokens pending.
- ap_start_int  out  1  start to loop body.
- ap_ready_int  in  1  body accepted an iteration.
- ap_done_int  in  1  body completed a run (1-cycle pulse).
- ap_continue_int  out  1  credit available to body.
- ap_loop_init  out  1  init-phase qualifier for live-in init ops.
- ap_loop_exit_ready  in  1  body exit ready.
- ap_loop_exit_done  in  1  body exit done; re-arms init.
- done_count  out  CNT_W  current token count.
- overflow_err  out  1  sticky: ap_done_int arrived with no credit.

Behaviour:
- Reset (ap_rst_n=0, async assert, sync-safe release): cnt=0, init_active=1, init_cnt=0, busy=0, overflow_err=0. done_count=0 while in reset. Combinational outputs follow their equations using the reset state.
- credit = (cnt < DONE_DEPTH). ap_continue_int = credit. ap_start_int = ap_start & credit.
- ap_done = ap_done_int | (cnt != 0). This is a combinational bypass: zero-latency done on the pulse cycle.
- consume = ap_done & (HAS_CONTINUE ? ap_continue : ap_start).
- Counter update, cnt_next = cnt + inc - consume, where inc = ap_done_int & credit:
  - Simultaneous inc and consume: cnt unchanged.
  - consume with cnt=0 and ap_done_int=1 (bypass): cnt stays 0.
  - Never underflows; consume without ap_done is impossible by construction.
- Overflow: ap_done_int=1 while credit=0 sets overflow_err (sticky until reset). The token is dropped and cnt saturates at DONE_DEPTH.
- Init window:
  - ap_loop_init = init_active & ap_start.
  - On ap_loop_exit_done: init_active<=1 and init_cnt<=0. This has priority over ap_ready_int in the same cycle.
  - Otherwise, on ap_ready_int while init_active: init_cnt increments. When init_cnt reaches INIT_ITERS-1 on that pulse, init_active<=0.
  - With INIT_ITERS=1, init clears on the first ap_ready_int.
- Busy:
  - busy <= 1 if ap_start_int.
  - else busy <= 0 if ap_loop_exit_done.
  - else busy holds.
- ap_idle = ~busy & (cnt==0) & ~ap_done_int.
- ap_ready = ap_loop_exit_ready (combinational passthrough).
- Reset mid-run: all state cleared immediately; pending tokens are lost; init re-armed.

Test Plan:
- Reset release, ap_start=1, INIT_ITERS=3 -> ap_loop_init=1 through the 3rd ap_ready_int pulse, 0 afterwards. ap_loop_exit_done pulse -> ap_loop_init=1 again next cycle (with ap_start=1).
- HAS_CONTINUE=1, DONE_DEPTH=2, ap_continue=0, two ap_done_int pulses -> done_count=2, ap_continue_int=0, ap_start_int=0 despite ap_start=1. Then ap_continue=1 for 2 cycles -> done_count 1 then 0; ap_done drops and ap_continue_int returns to 1.
- ap_done_int with cnt=0 and ap_continue=1 -> ap_done=1 the same cycle, done_count stays 0. Simultaneous ap_done_int and consume with cnt=1 -> done_count stays 1.
- Credit exhausted (cnt=2) plus ap_done_int pulse -> overflow_err=1 and stays 1, done_count=2. Only ap_rst_n low clears it.
- HAS_CONTINUE=0: ap_done_int with ap_start=0 -> ap_done held high. Raising ap_start -> token consumed, ap_done falls the next cycle (legacy done-cache behaviour).
- Assert ap_rst_n=0 mid-run with cnt=1, busy=1 -> done_count=0, ap_idle=1, ap_done=0 immediately without a clock edge.

Source files
------------

// File: rtl/predictor_flow_control_loop_pipe_credit.sv
// Loop flow-control wrapper between the parent FSM and a pipelined HLS loop body.
// Tracks completed runs as done tokens gated by a DONE_DEPTH credit limit,
// provides a multi-iteration ap_loop_init window, idle/busy status and a
// sticky overflow flag for done pulses that arrive without credit.
module predictor_flow_control_loop_pipe_credit #(
    parameter int unsigned DONE_DEPTH   = 2,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned HAS_CONTINUE = 1,
    parameter int unsigned INIT_ITERS   = 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             ap_continue,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_start_int,
    input  logic             ap_ready_int,
    input  logic             ap_done_int,
    output logic             ap_continue_int,
    output logic             ap_loop_init,
    input  logic             ap_loop_exit_ready,
    input  logic             ap_loop_exit_done,
    output logic [CNT_W-1:0] done_count,
    output logic             overflow_err
);

    localparam int unsigned INIT_W = 8;
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(DONE_DEPTH);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_ITERS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [INIT_W-1:0] init_cnt;
    logic              init_active;
    logic              busy;
    logic              credit;
    logic              consume;
    logic              inc;

    // Credit, handshake and status outputs derived from the current state
    always_comb begin
        credit          = (cnt < DEPTH);
        ap_continue_int = credit;
        ap_start_int    = ap_start & credit;
        ap_done         = ap_done_int | (cnt != '0);
        consume         = ap_done & ((HAS_CONTINUE != 0) ? ap_continue : ap_start);
        inc             = ap_done_int & credit;
        ap_loop_init    = init_active & ap_start;
        ap_idle         = ~busy & (cnt == '0) & ~ap_done_int;
        ap_ready        = ap_loop_exit_ready;
        done_count      = cnt;
    end

    // Token count: a produced and a consumed token in one cycle cancel out
    always_comb begin
        cnt_next = cnt;
        if (inc && !consume) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!inc && consume && (cnt != '0)) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Token counter and sticky overflow on a done pulse without credit
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt          <= '0;
            overflow_err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (ap_done_int && !credit) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Init window: armed for INIT_ITERS accepted iterations, re-armed on loop exit
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            init_active <= 1'b1;
            init_cnt    <= '0;
        end else if (ap_loop_exit_done) begin
            init_active <= 1'b1;
            init_cnt    <= '0;
        end else if (ap_ready_int && init_active) begin
            init_cnt <= init_cnt + INIT_W'(1);
            if (init_cnt == INIT_LAST) begin
                init_active <= 1'b0;
            end
        end
    end

    // Busy from an accepted start until the loop body reports exit
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy <= 1'b0;
        end else if (ap_start_int) begin
            busy <= 1'b1;
        end else if (ap_loop_exit_done) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_predictor_flow_control_loop_pipe_credit.sv
// Bench for the loop flow-control wrapper: two instances (continue mode with a
// 3-iteration init window, legacy start-handshake mode) share stimulus and are
// compared every cycle against a token/iteration-count model.
module tb_predictor_flow_control_loop_pipe_credit;

    localparam int unsigned DD = 2;
    localparam int unsigned CW = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_continue = 1'b0;
    logic ap_ready_int = 1'b0;
    logic ap_done_int = 1'b0;
    logic ap_loop_exit_ready = 1'b0;
    logic ap_loop_exit_done = 1'b0;

    logic          o_ready [2];
    logic          o_done [2];
    logic          o_idle [2];
    logic          o_start_int [2];
    logic          o_cont_int [2];
    logic          o_init [2];
    logic [CW-1:0] o_cnt [2];
    logic          o_ovf [2];

    int checks = 0;
    int errors = 0;

    // model state: tokens held, iterations accepted since re-arm, run active, overflow seen
    int m_tokens [2];
    int m_iters [2];
    bit m_run [2];
    bit m_ovf [2];
    int p_hc [2] = '{1, 0};
    int p_ii [2] = '{3, 1};

    always #5 ap_clk = ~ap_clk;

    predictor_flow_control_loop_pipe_credit #(
        .DONE_DEPTH(DD), .CNT_W(CW), .HAS_CONTINUE(1), .INIT_ITERS(3)
    ) u_dut_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(o_ready[0]), .ap_done(o_done[0]), .ap_idle(o_idle[0]),
        .ap_start_int(o_start_int[0]), .ap_ready_int(ap_ready_int), .ap_done_int(ap_done_int),
        .ap_continue_int(o_cont_int[0]), .ap_loop_init(o_init[0]),
        .ap_loop_exit_ready(ap_loop_exit_ready), .ap_loop_exit_done(ap_loop_exit_done),
        .done_count(o_cnt[0]), .overflow_err(o_ovf[0])
    );

    predictor_flow_control_loop_pipe_credit #(
        .DONE_DEPTH(DD), .CNT_W(CW), .HAS_CONTINUE(0), .INIT_ITERS(1)
    ) u_dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(o_ready[1]), .ap_done(o_done[1]), .ap_idle(o_idle[1]),
        .ap_start_int(o_start_int[1]), .ap_ready_int(ap_ready_int), .ap_done_int(ap_done_int),
        .ap_continue_int(o_cont_int[1]), .ap_loop_init(o_init[1]),
        .ap_loop_exit_ready(ap_loop_exit_ready), .ap_loop_exit_done(ap_loop_exit_done),
        .done_count(o_cnt[1]), .overflow_err(o_ovf[1])
    );

    function automatic bit has_credit(int i);
        return m_tokens[i] < int'(DD);
    endfunction

    function automatic bit exp_done(int i);
        return ap_done_int || (m_tokens[i] != 0);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // model advance on each clock edge, cleared asynchronously by reset
    always @(posedge ap_clk or negedge ap_rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!ap_rst_n) begin
                m_tokens[i] <= 0;
                m_iters[i]  <= 0;
                m_run[i]    <= 1'b0;
                m_ovf[i]    <= 1'b0;
            end else begin
                automatic bit cr   = has_credit(i);
                automatic bit take = exp_done(i) && ((p_hc[i] != 0) ? ap_continue : ap_start);
                automatic bit add  = ap_done_int && cr;
                m_tokens[i] <= m_tokens[i] + int'(add) - int'(take);
                if (ap_done_int && !cr) m_ovf[i] <= 1'b1;
                if (ap_loop_exit_done) m_iters[i] <= 0;
                else if (ap_ready_int && m_iters[i] < p_ii[i]) m_iters[i] <= m_iters[i] + 1;
                if (ap_start && cr) m_run[i] <= 1'b1;
                else if (ap_loop_exit_done) m_run[i] <= 1'b0;
            end
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge ap_clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic bit cr = has_credit(i);
            chk($sformatf("done_count[%0d]", i), int'(o_cnt[i]), m_tokens[i]);
            chk($sformatf("ap_done[%0d]", i), int'(o_done[i]), int'(exp_done(i)));
            chk($sformatf("ap_continue_int[%0d]", i), int'(o_cont_int[i]), int'(cr));
            chk($sformatf("ap_start_int[%0d]", i), int'(o_start_int[i]), int'(ap_start && cr));
            chk($sformatf("ap_loop_init[%0d]", i), int'(o_init[i]),
                int'((m_iters[i] < p_ii[i]) && ap_start));
            chk($sformatf("ap_idle[%0d]", i), int'(o_idle[i]),
                int'(!m_run[i] && m_tokens[i] == 0 && !ap_done_int));
            chk($sformatf("ap_ready[%0d]", i), int'(o_ready[i]), int'(ap_loop_exit_ready));
            chk($sformatf("overflow_err[%0d]", i), int'(o_ovf[i]), int'(m_ovf[i]));
        end
    end

    // advance to just after the next rising edge, where inputs are driven
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        ap_start = 0; ap_continue = 0; ap_ready_int = 0; ap_done_int = 0;
        ap_loop_exit_ready = 0; ap_loop_exit_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ap_rst_n = 0;
        step();
        step();
        ap_rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        ap_rst_n = 0;
        #3;
        chk("reset done_count", int'(o_cnt[0]), 0);
        chk("reset ap_idle", int'(o_idle[0]), 1);
        chk("reset ap_done", int'(o_done[0]), 0);
        chk("reset overflow", int'(o_ovf[0]), 0);
        step();
        ap_rst_n = 1;

        // init window spans three accepted iterations, re-armed by loop exit
        ap_start = 1;
        settle();
        chk("init armed", int'(o_init[0]), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            ap_ready_int = 1;
            settle();
            chk($sformatf("init during pulse %0d", k + 1), int'(o_init[0]), 1);
        end
        step();
        ap_ready_int = 0;
        settle();
        chk("init cleared", int'(o_init[0]), 0);
        step();
        ap_loop_exit_done = 1;
        step();
        ap_loop_exit_done = 0;
        settle();
        chk("init re-armed", int'(o_init[0]), 1);

        // credit exhaustion and drain by ap_continue
        step();
        ap_continue = 0;
        ap_done_int = 1;
        step();
        step();
        ap_done_int = 0;
        settle();
        chk("two tokens", int'(o_cnt[0]), 2);
        chk("no credit", int'(o_cont_int[0]), 0);
        chk("start blocked", int'(o_start_int[0]), 0);
        step();
        ap_continue = 1;
        step();
        settle();
        chk("drain to 1", int'(o_cnt[0]), 1);
        step();
        settle();
        chk("drain to 0", int'(o_cnt[0]), 0);
        chk("done dropped", int'(o_done[0]), 0);
        chk("credit back", int'(o_cont_int[0]), 1);

        // zero-latency bypass, then simultaneous produce and consume at one token
        ap_done_int = 1;
        settle();
        chk("bypass done", int'(o_done[0]), 1);
        step();
        ap_done_int = 0;
        settle();
        chk("bypass count", int'(o_cnt[0]), 0);
        ap_continue = 0;
        ap_done_int = 1;
        step();
        ap_continue = 1;
        step();
        ap_done_int = 0;
        ap_continue = 0;
        settle();
        chk("simultaneous hold", int'(o_cnt[0]), 1);

        // overflow with credit exhausted is sticky
        step();
        ap_done_int = 1;
        step();
        step();
        ap_done_int = 0;
        settle();
        chk("overflow set", int'(o_ovf[0]), 1);
        chk("overflow count", int'(o_cnt[0]), 2);
        repeat (3) step();
        chk("overflow sticky", int'(o_ovf[0]), 1);

        // legacy start-handshake consumption
        do_reset();
        settle();
        chk("overflow cleared", int'(o_ovf[0]), 0);
        step();
        ap_done_int = 1;
        step();
        ap_done_int = 0;
        step();
        settle();
        chk("legacy done held", int'(o_done[1]), 1);
        ap_start = 1;
        step();
        settle();
        chk("legacy consumed", int'(o_done[1]), 0);
        chk("legacy count", int'(o_cnt[1]), 0);

        // reset mid-run clears state without a clock edge
        do_reset();
        ap_start = 1;
        ap_continue = 0;
        ap_done_int = 1;
        step();
        ap_done_int = 0;
        ap_start = 0;
        settle();
        chk("pre-reset count", int'(o_cnt[0]), 1);
        chk("pre-reset busy", int'(o_idle[0]), 0);
        ap_rst_n = 0;
        #1;
        chk("async count", int'(o_cnt[0]), 0);
        chk("async idle", int'(o_idle[0]), 1);
        chk("async done", int'(o_done[0]), 0);
        step();
        ap_rst_n = 1;

        // randomized traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            step();
            ap_start           = ($urandom_range(0, 3) != 0);
            ap_continue        = ($urandom_range(0, 2) == 0);
            ap_ready_int       = ($urandom_range(0, 1) == 0);
            ap_done_int        = ($urandom_range(0, 4) == 0);
            ap_loop_exit_ready = ($urandom_range(0, 5) == 0);
            ap_loop_exit_done  = ($urandom_range(0, 7) == 0);
            ap_rst_n           = ($urandom_range(0, 149) != 0);
        end
        step();
        clear_inputs();
        ap_rst_n = 1;
        step();
        @(negedge ap_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
